// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, ASCII constants and letter helpers for the guess scheduler
// Purpose: scheduler state encoding, letter constants, case normalization helpers.
// Ports: none (package).
package game_pkg;

    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_Z      = 8'h5A;
    localparam logic [7:0] LOWER_OFFSET = 8'h20;
    localparam int         NUM_LETTERS  = 26;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        HALT
    } sched_state_t;

    // Lowercase folds onto uppercase; every other code passes through untouched.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if ((c >= (ASCII_A + LOWER_OFFSET)) && (c <= (ASCII_Z + LOWER_OFFSET)))
            return c - LOWER_OFFSET;
        return c;
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        logic [7:0] u;
        u = to_upper(c);
        return (u >= ASCII_A) && (u <= ASCII_Z);
    endfunction

endpackage

// File: rtl/guess_sched_if.sv
// rtl/guess_sched_if.sv - requester and engine handshake bundle for the guess scheduler
// Purpose: groups the two-requester guess handshake and the engine handshake.
// Ports: req_valid/req_letter0/req_letter1 -> req_ack/req_dup (requesters),
//        eng_rdy/eng_busy -> eng_guess/eng_start (game engine).
//        master = environment side, slave = scheduler side.
interface guess_sched_if;

    logic [1:0] req_valid;
    logic [7:0] req_letter0;
    logic [7:0] req_letter1;
    logic [1:0] req_ack;
    logic [1:0] req_dup;
    logic       eng_rdy;
    logic       eng_busy;
    logic [7:0] eng_guess;
    logic       eng_start;

    modport master (
        output req_valid, req_letter0, req_letter1, eng_rdy, eng_busy,
        input  req_ack, req_dup, eng_guess, eng_start
    );

    modport slave (
        input  req_valid, req_letter0, req_letter1, eng_rdy, eng_busy,
        output req_ack, req_dup, eng_guess, eng_start
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with internal pointer
// Purpose: grants one of two requesters when enabled; ties go to the pointer side.
// Ports: clk, rst (async active-high), clr (sync pointer clear), en (grant allowed),
//        req[1:0] requests, gnt[1:0] one-hot grant (combinational).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11)
                gnt = ptr ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    // After any grant the pointer moves to the side that lost (or was idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (clr)
            ptr <= 1'b0;
        else if (|gnt)
            ptr <= ~gnt[1];
    end

endmodule

// File: rtl/guess_sched.sv
// rtl/guess_sched.sv - letter-guess scheduler between two requesters and a game engine
// Purpose: arbitrates guess requests, rejects invalid/repeated letters, issues guesses
//          to the engine and supervises its busy handshake with a timeout.
// Ports: clk, rst (async active-high), bus (guess_sched_if.slave),
//        new_round / game_over (round control), used_mask[25:0], timeout pulse.
module guess_sched
    import game_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                   clk,
    input  logic                   rst,
    guess_sched_if.slave           bus,
    input  logic                   new_round,
    input  logic                   game_over,
    output logic [NUM_LETTERS-1:0] used_mask,
    output logic                   timeout
);

    sched_state_t     state;
    sched_state_t     nxt;
    logic [1:0]       gnt_raw;
    logic [1:0]       gnt_q;
    logic [7:0]       letter_q;
    logic [7:0]       guess_q;
    logic [15:0]      cnt;
    logic [7:0]       upper;
    logic             letter_ok;
    logic [4:0]       idx;
    logic [NUM_LETTERS-1:0] letter_bit;
    logic             reject;
    logic             arb_en;

    // Round control wins over a grant, so the arbiter is only enabled when the
    // IDLE state will actually advance to CHECK.
    assign arb_en = (state == IDLE) && bus.eng_rdy && !new_round && !game_over;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .clr (new_round),
        .en  (arb_en),
        .req (bus.req_valid),
        .gnt (gnt_raw)
    );

    assign upper      = to_upper(letter_q);
    assign letter_ok  = is_letter(letter_q);
    assign idx        = 5'(upper - ASCII_A);
    assign letter_bit = letter_ok ? (NUM_LETTERS'(1) << idx) : '0;
    assign reject     = !letter_ok || ((used_mask & letter_bit) != '0);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (|gnt_raw) nxt = CHECK;
            CHECK:     nxt = reject ? IDLE : ISSUE;
            ISSUE:     nxt = WAIT_BUSY;
            // Reaching the limit ends the wait even if busy shows up that same cycle.
            WAIT_BUSY: if (cnt == TIMEOUT_CYCLES) nxt = IDLE;
                       else if (bus.eng_busy)     nxt = WAIT_DONE;
            WAIT_DONE: if (!bus.eng_busy && bus.eng_rdy) nxt = IDLE;
            HALT:      nxt = HALT;
            default:   nxt = IDLE;
        endcase
        if (game_over && (state != HALT))
            nxt = HALT;
        if (new_round)
            nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= 2'b00;
            letter_q  <= 8'h00;
            guess_q   <= 8'h00;
            cnt       <= 16'd0;
            used_mask <= '0;
        end else begin
            state <= nxt;
            if ((state == IDLE) && (nxt == CHECK)) begin
                gnt_q    <= gnt_raw;
                letter_q <= gnt_raw[1] ? bus.req_letter1 : bus.req_letter0;
            end
            if (new_round) begin
                cnt       <= 16'd0;
                used_mask <= '0;
            end else begin
                if (state == ISSUE)
                    cnt <= 16'd0;
                else if (state == WAIT_BUSY)
                    cnt <= cnt + 16'd1;
                if ((state == CHECK) && (nxt == ISSUE)) begin
                    used_mask <= used_mask | letter_bit;
                    guess_q   <= upper;
                end
            end
        end
    end

    assign bus.req_ack   = (state == CHECK) ? gnt_q : 2'b00;
    assign bus.req_dup   = ((state == CHECK) && reject) ? gnt_q : 2'b00;
    assign bus.eng_start = (state == ISSUE);
    assign bus.eng_guess = guess_q;
    assign timeout       = (state == WAIT_BUSY) && (cnt == TIMEOUT_CYCLES);

endmodule

// File: tb/tb_guess_sched.sv
// tb/tb_guess_sched.sv - self-checking bench for guess_sched
module tb_guess_sched;

    localparam logic [15:0] TOUT = 16'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_round;
    logic        game_over;
    logic [25:0] used_mask;
    logic        timeout;

    guess_sched_if bus ();

    guess_sched #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .new_round (new_round),
        .game_over (game_over),
        .used_mask (used_mask),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: set of guessed letters and whose turn it is on a tie.
    bit m_used [26];
    int m_turn;

    task automatic model_clear();
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_turn = 0;
    endtask

    function automatic logic [25:0] model_mask();
        logic [25:0] r;
        for (int i = 0; i < 26; i++) r[i] = m_used[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full guess transaction; busy < 0 means the engine never answers.
    task automatic do_guess(input logic [1:0] v, input logic [7:0] l0, input logic [7:0] l1,
                            input int busy);
        int         w;
        int         n;
        int         idx;
        logic [7:0] c;
        logic [7:0] up;
        bit         ok;
        bit         dup;
        w      = (v == 2'b11) ? m_turn : ((v == 2'b10) ? 1 : 0);
        m_turn = 1 - w;
        c      = (w == 1) ? l1 : l0;
        up     = c;
        if (c >= 8'h61 && c <= 8'h7A) up = c - 8'd32;
        ok     = (up >= 8'h41 && up <= 8'h5A);
        idx    = ok ? (int'(up) - 65) : 0;
        dup    = !ok || m_used[idx];

        bus.req_valid   = v;
        bus.req_letter0 = l0;
        bus.req_letter1 = l1;
        bus.eng_rdy     = 1'b1;
        bus.eng_busy    = 1'b0;
        step();
        bus.req_valid = 2'b00;
        chk("ack", bus.req_ack, (w == 1) ? 32'd2 : 32'd1);
        chk("dup", bus.req_dup, dup ? ((w == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk("start_in_check", bus.eng_start, 0);
        step();
        chk("ack_pulse", bus.req_ack, 0);
        if (dup) begin
            chk("no_start", bus.eng_start, 0);
            chk("mask_kept", used_mask, model_mask());
            return;
        end
        m_used[idx] = 1'b1;
        chk("start", bus.eng_start, 1);
        chk("guess", bus.eng_guess, up);
        chk("mask", used_mask, model_mask());
        step();
        chk("start_pulse", bus.eng_start, 0);
        if (busy < 0) begin
            n = 0;
            while (n < 100 && timeout !== 1'b1) begin
                step();
                n++;
            end
            chk("timeout_after", n, TOUT);
            step();
            chk("timeout_pulse", timeout, 0);
            chk("mask_after_timeout", used_mask, model_mask());
        end else begin
            bus.eng_busy = 1'b1;
            bus.eng_rdy  = 1'b0;
            repeat (busy + 1) step();
            chk("no_timeout", timeout, 0);
            bus.eng_busy = 1'b0;
            bus.eng_rdy  = 1'b1;
            step();
        end
    endtask

    task automatic pulse_ctrl(input logic nr, input logic go);
        new_round = nr;
        game_over = go;
        step();
        new_round = 1'b0;
        game_over = 1'b0;
        if (nr) model_clear();
    endtask

    function automatic logic [7:0] rand_letter();
        case ($urandom_range(0, 2))
            0:       return 8'h61 + 8'($urandom_range(0, 25));
            1:       return 8'h41 + 8'($urandom_range(0, 25));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst             = 1'b1;
        new_round       = 1'b0;
        game_over       = 1'b0;
        bus.req_valid   = 2'b00;
        bus.req_letter0 = 8'h00;
        bus.req_letter1 = 8'h00;
        bus.eng_rdy     = 1'b0;
        bus.eng_busy    = 1'b0;
        model_clear();
        step();
        step();
        chk("rst_ack", bus.req_ack, 0);
        chk("rst_dup", bus.req_dup, 0);
        chk("rst_start", bus.eng_start, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_mask", used_mask, 0);
        chk("rst_guess", bus.eng_guess, 0);
        rst = 1'b0;

        // Engine not ready: request must wait.
        bus.req_valid   = 2'b01;
        bus.req_letter0 = "c";
        repeat (3) begin
            step();
            chk("wait_rdy", bus.req_ack, 0);
        end
        bus.req_valid = 2'b00;
        step();

        do_guess(2'b01, 8'h63, 8'h00, 1);
        pulse_ctrl(1'b1, 1'b0);
        chk("new_round_mask", used_mask, 0);

        do_guess(2'b11, "c", "d", 0);
        do_guess(2'b11, "z", "e", 2);
        do_guess(2'b01, "C", 8'h00, 0);
        do_guess(2'b10, 8'h00, 8'h31, 0);
        do_guess(2'b01, "t", 8'h00, -1);
        do_guess(2'b10, 8'h00, "k", 2);

        for (int i = 0; i < 30; i++) begin
            int b;
            b = int'($urandom_range(0, 4));
            do_guess(2'($urandom_range(1, 3)), rand_letter(), rand_letter(), (b == 4) ? -1 : b);
        end

        // game_over while the engine is evaluating.
        pulse_ctrl(1'b1, 1'b0);
        bus.req_valid   = 2'b01;
        bus.req_letter0 = "g";
        bus.eng_rdy     = 1'b1;
        step();
        bus.req_valid = 2'b00;
        chk("g_ack", bus.req_ack, 1);
        step();
        step();
        bus.eng_busy = 1'b1;
        bus.eng_rdy  = 1'b0;
        step();
        pulse_ctrl(1'b0, 1'b1);
        m_used[6]       = 1'b1;
        bus.eng_busy    = 1'b0;
        bus.eng_rdy     = 1'b1;
        bus.req_valid   = 2'b11;
        bus.req_letter0 = "h";
        bus.req_letter1 = "i";
        repeat (4) begin
            step();
            chk("halt_ack", bus.req_ack, 0);
            chk("halt_start", bus.eng_start, 0);
        end
        chk("halt_mask", used_mask, model_mask());
        bus.req_valid = 2'b00;
        pulse_ctrl(1'b1, 1'b0);
        chk("halt_clear_mask", used_mask, 0);
        do_guess(2'b11, "h", "i", 0);

        pulse_ctrl(1'b1, 1'b1);
        do_guess(2'b11, "a", "b", 1);

        // Reset while CHECK is showing an ack: it must vanish immediately.
        bus.req_valid   = 2'b10;
        bus.req_letter1 = "q";
        step();
        bus.req_valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("rst_check_ack", bus.req_ack, 0);
        step();
        rst = 1'b0;
        model_clear();
        step();
        chk("rst_check_no_start", bus.eng_start, 0);

        // Reset while waiting for busy.
        bus.req_valid   = 2'b01;
        bus.req_letter0 = "m";
        step();
        bus.req_valid = 2'b00;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_wb_mask", used_mask, 0);
        chk("rst_wb_guess", bus.eng_guess, 0);
        chk("rst_wb_timeout", timeout, 0);
        chk("rst_wb_start", bus.eng_start, 0);
        step();
        rst = 1'b0;
        model_clear();
        do_guess(2'b11, "m", "n", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
